ram_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the req/addr_ok/data_ok memory bus.
- Lets the instruction port (m0) and the data port (m1) share a single RAM or peripheral target port.
- Round-robin grant on the address phase.
- An in-order ID FIFO of outstanding transactions routes data_ok/rdata back to the master that issued each request. No response-ordering assumption is placed on the masters.

---
 rtl/ram_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// Two-master / one-slave arbiter for the req/addr_ok/data_ok memory bus.
// Round-robin address grant with a lock across slave stalls; an in-order
// ID FIFO steers each data_ok/rdata back to the master that issued it.
//
// Ports:
//   clk, rst_b       clock, async active-low reset
//   mN_req/write/wstrb/addr/wdata   master N request payload (N = 0, 1)
//   mN_addr_ok       master N request accepted this cycle
//   mN_data_ok       master N response valid, mN_rdata carries the data
//   s_*              forwarded request to / response from the slave
//   err_unexp        pulse: slave response with nothing outstanding
module ram_bus_arbiter #(
    parameter int XLEN        = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [XLEN/8-1:0] m0_wstrb,
    input  logic [XLEN-1:0]   m0_addr,
    input  logic [XLEN-1:0]   m0_wdata,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,
    output logic [XLEN-1:0]   m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [XLEN/8-1:0] m1_wstrb,
    input  logic [XLEN-1:0]   m1_addr,
    input  logic [XLEN-1:0]   m1_wdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,
    output logic [XLEN-1:0]   m1_rdata,
    output logic              s_req,
    output logic              s_write,
    output logic [XLEN/8-1:0] s_wstrb,
    output logic [XLEN-1:0]   s_addr,
    output logic [XLEN-1:0]   s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [XLEN-1:0]   s_rdata,
    output logic              err_unexp
);

    localparam int PTR_W = $clog2(OUTSTANDING) + 1;
    localparam int IDX_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] FULL = PTR_W'(OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUTSTANDING - 1);

    logic                   r_last_gnt;
    logic                   r_lock_vld;
    logic                   r_lock_id;
    logic [OUTSTANDING-1:0] r_fifo;
    logic [IDX_W-1:0]       r_wr_ptr;
    logic [IDX_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_count;

    logic             w_gnt;
    logic             w_full;
    logic             w_empty;
    logic             w_s_req;
    logic             w_accept;
    logic             w_pop;
    logic             w_head;
    logic [IDX_W-1:0] w_wr_nxt;
    logic [IDX_W-1:0] w_rd_nxt;

    // A stalled request stays with its master until the slave takes it.
    always_comb begin
        w_gnt = 1'b0;
        if (r_lock_vld)
            w_gnt = r_lock_id;
        else if (m0_req & m1_req)
            w_gnt = ~r_last_gnt;
        else
            w_gnt = m1_req;
    end

    // rst_b gates every output so the bus is quiet while in reset.
    assign w_full   = (r_count == FULL);
    assign w_empty  = (r_count == '0);
    assign w_s_req  = rst_b & (m0_req | m1_req) & ~w_full;
    assign w_accept = w_s_req & s_addr_ok;
    assign w_pop    = rst_b & s_data_ok & ~w_empty;
    assign w_head   = r_fifo[r_rd_ptr];
    assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;

    assign s_req   = w_s_req;
    assign s_write = w_s_req & (w_gnt ? m1_write : m0_write);
    assign s_wstrb = w_s_req ? (w_gnt ? m1_wstrb : m0_wstrb) : '0;
    assign s_addr  = w_s_req ? (w_gnt ? m1_addr : m0_addr) : '0;
    assign s_wdata = w_s_req ? (w_gnt ? m1_wdata : m0_wdata) : '0;

    assign m0_addr_ok = w_accept & ~w_gnt;
    assign m1_addr_ok = w_accept & w_gnt;
    assign m0_data_ok = w_pop & ~w_head;
    assign m1_data_ok = w_pop & w_head;
    assign m0_rdata   = m0_data_ok ? s_rdata : '0;
    assign m1_rdata   = m1_data_ok ? s_rdata : '0;
    assign err_unexp  = rst_b & s_data_ok & w_empty;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_last_gnt <= 1'b1;
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
            r_fifo     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_gnt;
                r_wr_ptr         <= w_wr_nxt;
                r_last_gnt       <= w_gnt;
                r_lock_vld       <= 1'b0;
            end else if (w_s_req) begin
                r_lock_vld <= 1'b1;
                r_lock_id  <= w_gnt;
            end
            if (w_pop)
                r_rd_ptr <= w_rd_nxt;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: directed stimulus pushes expected
// accepts/responses/errors, a negedge monitor pops and compares them.
module tb_ram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_write;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err_unexp;

    typedef struct {
        logic        id;
        logic [31:0] addr;
    } acc_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_r0[$];
    logic [31:0] exp_r1[$];
    int          exp_err[$];

    int n_tests = 0;
    int n_fail  = 0;

    ram_bus_arbiter #(.XLEN(32), .OUTSTANDING(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .m0_req(m0_req), .m0_write(m0_write), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every asserted DUT event must match the head of its queue.
    always @(negedge clk) begin
        acc_t e;
        if (m0_addr_ok || m1_addr_ok) begin
            chk("acc_onehot", {31'b0, m0_addr_ok & m1_addr_ok}, 32'h0);
            chk("acc_expected", {31'b0, exp_acc.size() != 0}, 32'h1);
            if (exp_acc.size() != 0) begin
                e = exp_acc.pop_front();
                chk("acc_id", {31'b0, m1_addr_ok}, {31'b0, e.id});
                chk("acc_addr", s_addr, e.addr);
            end
        end
        if (m0_data_ok) begin
            chk("r0_expected", {31'b0, exp_r0.size() != 0}, 32'h1);
            if (exp_r0.size() != 0)
                chk("m0_rdata", m0_rdata, exp_r0.pop_front());
        end else begin
            chk("m0_rdata_idle", m0_rdata, 32'h0);
        end
        if (m1_data_ok) begin
            chk("r1_expected", {31'b0, exp_r1.size() != 0}, 32'h1);
            if (exp_r1.size() != 0)
                chk("m1_rdata", m1_rdata, exp_r1.pop_front());
        end else begin
            chk("m1_rdata_idle", m1_rdata, 32'h0);
        end
        if (err_unexp) begin
            chk("err_expected", {31'b0, exp_err.size() != 0}, 32'h1);
            chk("err_no_dok", {31'b0, m0_data_ok | m1_data_ok}, 32'h0);
            if (exp_err.size() != 0)
                void'(exp_err.pop_front());
        end
    end

    task automatic idle_in();
        m0_req = 0; m0_write = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic m0(input logic [31:0] a);
        m0_req = 1; m0_addr = a;
    endtask

    task automatic m1(input logic [31:0] a);
        m1_req = 1; m1_addr = a;
    endtask

    task automatic rsp(input logic [31:0] d);
        s_data_ok = 1; s_rdata = d;
    endtask

    task automatic do_reset();
        rst_b = 0;
        #2;
        rst_b = 1;
    endtask

    initial begin
        rst_b = 0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        // Requests and a response driven during reset must be masked.
        m0(32'h10); s_addr_ok = 1; rsp(32'h1);
        #1;
        chk("rst_s_req", {31'b0, s_req}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_addr_ok", {31'b0, m0_addr_ok}, 32'h0);
        chk("rst_data_ok", {31'b0, m0_data_ok}, 32'h0);
        chk("rst_err", {31'b0, err_unexp}, 32'h0);
        idle_in();
        rst_b = 1;

        // Solo m0 read, response next cycle.
        cyc(); m0(32'h10); s_addr_ok = 1;
        exp_acc.push_back('{1'b0, 32'h10});
        cyc(); rsp(32'hDEADBEEF);
        exp_r0.push_back(32'hDEADBEEF);
        cyc();

        // Fresh round-robin: both requesting, slave always ready.
        do_reset();
        cyc(); m0(32'h100); m1(32'h200); s_addr_ok = 1;
        exp_acc.push_back('{1'b0, 32'h100});
        cyc(); m0(32'h104); m1(32'h200); s_addr_ok = 1; rsp(32'hA0);
        exp_acc.push_back('{1'b1, 32'h200}); exp_r0.push_back(32'hA0);
        cyc(); m0(32'h104); m1(32'h204); s_addr_ok = 1; rsp(32'hB0);
        exp_acc.push_back('{1'b0, 32'h104}); exp_r1.push_back(32'hB0);
        cyc(); m0(32'h108); m1(32'h204); s_addr_ok = 1; rsp(32'hA1);
        exp_acc.push_back('{1'b1, 32'h204}); exp_r0.push_back(32'hA1);
        cyc(); rsp(32'hB1);
        exp_r1.push_back(32'hB1);
        cyc();

        // m1 granted, slave stalls 3 cycles, m0 arrives mid-stall.
        cyc(); m1(32'h300);
        #1 chk("stall_addr0", s_addr, 32'h300);
        cyc(); m1(32'h300); m0(32'h310);
        #1 chk("stall_addr1", s_addr, 32'h300);
        cyc(); m1(32'h300); m0(32'h310);
        #1 chk("stall_addr2", s_addr, 32'h300);
        cyc(); m1(32'h300); m0(32'h310); s_addr_ok = 1;
        exp_acc.push_back('{1'b1, 32'h300});
        cyc(); m0(32'h310); s_addr_ok = 1;
        exp_acc.push_back('{1'b0, 32'h310});
        cyc(); rsp(32'hC1);
        exp_r1.push_back(32'hC1);
        cyc(); rsp(32'hC0);
        exp_r0.push_back(32'hC0);
        cyc();

        // Full FIFO: third m1 read waits until after the first response.
        cyc(); m1(32'h400); s_addr_ok = 1;
        exp_acc.push_back('{1'b1, 32'h400});
        cyc(); m1(32'h404); s_addr_ok = 1;
        exp_acc.push_back('{1'b1, 32'h404});
        cyc(); m1(32'h408); s_addr_ok = 1;
        #1 chk("full_s_req0", {31'b0, s_req}, 32'h0);
        cyc(); m1(32'h408); s_addr_ok = 1;
        #1 chk("full_s_req1", {31'b0, s_req}, 32'h0);
        cyc(); m1(32'h408); s_addr_ok = 1; rsp(32'hD0);
        exp_r1.push_back(32'hD0);
        #1 chk("full_pop_s_req", {31'b0, s_req}, 32'h0);
        cyc(); m1(32'h408); s_addr_ok = 1;
        exp_acc.push_back('{1'b1, 32'h408});
        #1 chk("full_resume", {31'b0, s_req}, 32'h1);
        cyc(); rsp(32'hD1);
        exp_r1.push_back(32'hD1);
        cyc(); rsp(32'hD2);
        exp_r1.push_back(32'hD2);
        cyc();

        // Interleaved m0 then m1, in-order responses.
        cyc(); m0(32'h500); s_addr_ok = 1;
        exp_acc.push_back('{1'b0, 32'h500});
        cyc(); m1(32'h504); s_addr_ok = 1;
        exp_acc.push_back('{1'b1, 32'h504});
        cyc(); rsp(32'h11);
        exp_r0.push_back(32'h11);
        cyc(); rsp(32'h22);
        exp_r1.push_back(32'h22);
        cyc();
        #1 chk("drain_count", {29'b0, dut.r_count}, 32'h0);

        // Unexpected response with nothing outstanding.
        cyc(); rsp(32'h55);
        exp_err.push_back(1);
        // Accept and response together from empty: push still happens.
        cyc(); m0(32'h600); s_addr_ok = 1; rsp(32'h56);
        exp_acc.push_back('{1'b0, 32'h600}); exp_err.push_back(1);
        cyc(); rsp(32'h66);
        exp_r0.push_back(32'h66);
        cyc(); m0(32'h700); s_addr_ok = 1;
        exp_acc.push_back('{1'b0, 32'h700});
        cyc(); m1(32'h710);
        cyc(); m1(32'h710);
        #1 chk("pre_rst_count", {29'b0, dut.r_count}, 32'h1);
        rst_b = 0; rsp(32'h88);
        #1;
        chk("mid_rst_count", {29'b0, dut.r_count}, 32'h0);
        chk("mid_rst_lock", {31'b0, dut.r_lock_vld}, 32'h0);
        chk("mid_rst_s_req", {31'b0, s_req}, 32'h0);
        chk("mid_rst_addr_ok", {31'b0, m1_addr_ok}, 32'h0);
        chk("mid_rst_data_ok", {31'b0, m0_data_ok | m1_data_ok}, 32'h0);
        chk("mid_rst_err", {31'b0, err_unexp}, 32'h0);
        idle_in();
        rst_b = 1;
        // Response to the pre-reset transaction is now unexpected.
        cyc(); rsp(32'h77);
        exp_err.push_back(1);
        cyc();
        cyc();
        chk("acc_q_empty", exp_acc.size(), 32'h0);
        chk("r0_q_empty", exp_r0.size(), 32'h0);
        chk("r1_q_empty", exp_r1.size(), 32'h0);
        chk("err_q_empty", exp_err.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
